// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Bundle of every ID/EX stage signal except clk and rst.
//                master : decode / forwarding side; drives the in_*, mem_*,
//                         wb_* and flush signals and observes the EX outputs.
//                slave  : the ID/EX stage itself.
//                Signals:
//                  in_valid, in_rs1/rs2/rd      decoded instruction and indices
//                  in_rd1/rd2/imm               register read data, immediate
//                  in_alu_src/reg_we/mem_rd     B-from-imm, writeback, load
//                  in_func                      ALU function code
//                  mem_rd/mem_reg_we/mem_data   MEM-stage forwarding source
//                  wb_rd/wb_reg_we/wb_data      WB-stage forwarding source
//                  flush                        squash the EX slot
//                  a, b, func                   ALU operands and function
//                  out_valid/rd/reg_we/mem_rd/illegal   EX slot status
//                  stall                        hold PC and IF/ID
//                  bubble_cnt                   count of load-use bubbles
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [4:0]       in_rd;
    logic [WIDTH-1:0] in_rd1;
    logic [WIDTH-1:0] in_rd2;
    logic [WIDTH-1:0] in_imm;
    logic             in_alu_src;
    logic             in_reg_we;
    logic             in_mem_rd;
    logic [3:0]       in_func;

    logic [4:0]       mem_rd;
    logic             mem_reg_we;
    logic [WIDTH-1:0] mem_data;

    logic [4:0]       wb_rd;
    logic             wb_reg_we;
    logic [WIDTH-1:0] wb_data;

    logic             flush;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       func;
    logic             out_valid;
    logic             out_reg_we;
    logic             out_mem_rd;
    logic             out_illegal;
    logic [4:0]       out_rd;
    logic             stall;
    logic [15:0]      bubble_cnt;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd1, in_rd2, in_imm,
               in_alu_src, in_reg_we, in_mem_rd, in_func,
               mem_rd, mem_reg_we, mem_data,
               wb_rd, wb_reg_we, wb_data, flush,
        input  a, b, func, out_valid, out_reg_we, out_mem_rd, out_illegal,
               out_rd, stall, bubble_cnt
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd1, in_rd2, in_imm,
               in_alu_src, in_reg_we, in_mem_rd, in_func,
               mem_rd, mem_reg_we, mem_data,
               wb_rd, wb_reg_we, wb_data, flush,
        output a, b, func, out_valid, out_reg_we, out_mem_rd, out_illegal,
               out_rd, stall, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with operand forwarding, load-use
//                hazard detection and illegal-function flagging.
//                Holds one EX slot; drives ALU operands a/b (forwarded from
//                MEM, then WB, then the captured register data) and func.
//                Ports:
//                  clk  single clock, rising edge
//                  rst  synchronous, active-high reset
//                  bus  id_ex_stage_if.slave (all datapath/control signals)
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    id_ex_stage_if.slave    bus
);

    localparam logic [3:0]  c_FUNC_BUBBLE = 4'b0000;
    localparam logic [4:0]  c_REG_ZERO    = 5'd0;
    localparam logic [15:0] c_CNT_MAX     = 16'hFFFF;

    // EX slot
    logic             r_valid;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_imm;
    logic             r_alu_src;
    logic             r_reg_we;
    logic             r_mem_rd;
    logic [3:0]       r_func;
    logic             r_illegal;
    logic [15:0]      r_bubble_cnt;

    logic             w_stall;
    logic             w_func_legal;
    logic [WIDTH-1:0] w_cap_op1;
    logic [WIDTH-1:0] w_cap_op2;
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;

    // Load-use hazard: a load in EX whose destination the incoming
    // instruction reads. A flush already kills the incoming instruction,
    // so no stall is needed then.
    always_comb begin
        w_stall = r_valid && r_mem_rd && bus.in_valid && (r_rd != c_REG_ZERO) &&
                  ((r_rd == bus.in_rs1) || (r_rd == bus.in_rs2)) && !bus.flush;
    end

    always_comb begin
        w_func_legal = 1'b0;
        case (bus.in_func)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0101, 4'b0110, 4'b0111: w_func_legal = 1'b1;
            default:                   w_func_legal = 1'b0;
        endcase
    end

    // The register file is written by WB in the same cycle it is read by
    // decode, so the captured operands take the WB value directly.
    always_comb begin
        w_cap_op1 = bus.in_rd1;
        w_cap_op2 = bus.in_rd2;
        if (bus.wb_reg_we && (bus.wb_rd != c_REG_ZERO) && (bus.wb_rd == bus.in_rs1)) begin
            w_cap_op1 = bus.wb_data;
        end
        if (bus.wb_reg_we && (bus.wb_rd != c_REG_ZERO) && (bus.wb_rd == bus.in_rs2)) begin
            w_cap_op2 = bus.wb_data;
        end
    end

    // EX-time forwarding: MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = r_op1;
        if (bus.mem_reg_we && (bus.mem_rd != c_REG_ZERO) && (bus.mem_rd == r_rs1)) begin
            w_fwd_a = bus.mem_data;
        end else if (bus.wb_reg_we && (bus.wb_rd != c_REG_ZERO) && (bus.wb_rd == r_rs1)) begin
            w_fwd_a = bus.wb_data;
        end

        w_fwd_b = r_op2;
        if (bus.mem_reg_we && (bus.mem_rd != c_REG_ZERO) && (bus.mem_rd == r_rs2)) begin
            w_fwd_b = bus.mem_data;
        end else if (bus.wb_reg_we && (bus.wb_rd != c_REG_ZERO) && (bus.wb_rd == r_rs2)) begin
            w_fwd_b = bus.wb_data;
        end
    end

    // Slot update: reset, then bubble (flush, stall or no instruction),
    // then normal capture. Bubble leaves the data fields untouched since
    // nothing downstream looks at them while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_rs1     <= c_REG_ZERO;
            r_rs2     <= c_REG_ZERO;
            r_rd      <= c_REG_ZERO;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_alu_src <= 1'b0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_func    <= c_FUNC_BUBBLE;
            r_illegal <= 1'b0;
        end else if (bus.flush || w_stall || !bus.in_valid) begin
            r_valid   <= 1'b0;
            r_reg_we  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_illegal <= 1'b0;
            r_func    <= c_FUNC_BUBBLE;
        end else begin
            r_valid   <= 1'b1;
            r_rs1     <= bus.in_rs1;
            r_rs2     <= bus.in_rs2;
            r_rd      <= bus.in_rd;
            r_op1     <= w_cap_op1;
            r_op2     <= w_cap_op2;
            r_imm     <= bus.in_imm;
            r_alu_src <= bus.in_alu_src;
            r_reg_we  <= bus.in_reg_we;
            r_mem_rd  <= bus.in_mem_rd;
            r_func    <= bus.in_func;
            r_illegal <= !w_func_legal;
        end
    end

    // Only load-use bubbles are counted; flush bubbles are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_stall && (r_bubble_cnt != c_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.a           = w_fwd_a;
    assign bus.b           = r_alu_src ? r_imm : w_fwd_b;
    assign bus.func        = r_func;
    assign bus.out_valid   = r_valid;
    assign bus.out_rd      = r_rd;
    assign bus.out_reg_we  = r_reg_we;
    assign bus.out_mem_rd  = r_mem_rd;
    assign bus.out_illegal = r_illegal;
    assign bus.stall       = w_stall;
    assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports in_valid (input, 1) and in_rs1, in_rs2, in_rd (input, 5 each): decoded instruction present and its register indices.
REQ-005 SHALL have ports in_rd1, in_rd2, in_imm (input, WIDTH each): register-file read data and immediate.
REQ-006 SHALL have ports in_alu_src, in_reg_we, in_mem_rd (input, 1 each) and in_func (input, 4): B-from-immediate select, writeback enable, load flag, ALU function code.
REQ-007 SHALL have ports mem_rd (input, 5), mem_reg_we (input, 1), mem_data (input, WIDTH): MEM-stage forwarding source.
REQ-008 SHALL have ports wb_rd (input, 5), wb_reg_we (input, 1), wb_data (input, WIDTH): WB-stage forwarding source.
REQ-009 SHALL have port flush  input  1  squash the EX-stage slot (taken branch/jump).
REQ-010 SHALL have ports a, b (output, WIDTH) and func (output, 4): operands and function code driven to the ALU.
REQ-011 SHALL have ports out_valid, out_reg_we, out_mem_rd, out_illegal (output, 1 each) and out_rd (output, 5): EX-slot status.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID (combinational).
REQ-013 SHALL have port bubble_cnt  output  16  count of inserted bubbles.

Function
REQ-014 SHALL hold one EX slot: valid, rs1, rs2, rd, op1, op2, imm, alu_src, reg_we, mem_rd, func, illegal.
REQ-015 SHALL assert stall = out_valid & out_mem_rd & in_valid & (out_rd != 0) & ((out_rd == in_rs1) | (out_rd == in_rs2)) & !flush.
REQ-016 SHALL per edge apply priority rst > flush > stall > capture.
REQ-017 SHALL on flush or stall load a bubble: valid, reg_we, mem_rd, illegal cleared, func = 0000; other fields don't-care.
REQ-018 SHALL on capture load all in_* fields, valid = in_valid; in_valid = 0 loads a bubble.
REQ-019 SHALL at capture replace in_rd1 (in_rd2) with wb_data when wb_reg_we, wb_rd != 0 and wb_rd == in_rs1 (in_rs2).
REQ-020 SHALL set illegal at capture when in_valid and in_func not in {0000,0001,0010,0011,0101,0110,0111}; func passes unchanged.
REQ-021 SHALL form fwd_a combinationally: mem_data if mem_reg_we & mem_rd != 0 & mem_rd == slot rs1; else wb_data if same test on WB; else slot op1. MEM beats WB.
REQ-022 SHALL form fwd_b identically on slot rs2 and op2.
REQ-023 SHALL drive a = fwd_a; b = slot imm if alu_src else fwd_b.
REQ-024 SHALL drive out_valid, out_rd, out_reg_we, out_mem_rd, out_illegal, func straight from the slot; latency in->out is one cycle.
REQ-025 SHALL increment bubble_cnt by 1 on each edge with stall = 1, saturating at 16'hFFFF; flush-bubbles not counted.
REQ-026 SHALL keep a stall at most one cycle per load-use pair: after the bubble the load leaves EX, so the test fails unless a new load occupies EX.
REQ-027 SHALL treat register index 0 as never forwarded and never hazarding.

Reset
REQ-028 SHALL on rst: out_valid, out_reg_we, out_mem_rd, out_illegal = 0, out_rd = 0, func = 0000, op1 = op2 = imm = 0, alu_src = 0, bubble_cnt = 0.
REQ-029 SHALL let rst override simultaneous flush, stall or capture; mid-stream reset drops the slot, first post-reset edge is a normal capture.

Verification
REQ-030 SHALL cover capture: in_valid=1, rs1=1, rs2=2, rd1=5, rd2=3, func=0001, alu_src=0, no forwarding -> next cycle a=5, b=3, func=0001, out_valid=1.
REQ-031 SHALL cover forwarding priority: slot rs1=4, mem_rd=4 (mem_data=0xAA), wb_rd=4 (wb_data=0xBB), both we=1 -> a=0xAA; drop mem_reg_we -> a=0xBB; rs1=0 -> a=op1.
REQ-032 SHALL cover load-use: EX load rd=7, in_rs2=7 -> stall=1 that cycle, next cycle out_valid=0, bubble_cnt=1, stall=0; following edge captures held instruction.
REQ-033 SHALL cover flush during hazard: same as REQ-032 with flush=1 -> stall=0, bubble loaded, bubble_cnt unchanged.
REQ-034 SHALL cover illegal func: in_func=0100 valid -> out_illegal=1, func=0100; in_func=1111 -> out_illegal=1.
REQ-035 SHALL cover reset and saturation: preload bubble_cnt=0xFFFE, two stall cycles -> 0xFFFF held; rst=1 with flush=1 and valid data -> all outputs per REQ-028.
